// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave arbiter for the sram-like bus.
// An in-order owner FIFO routes each memory response back to its issuing master.
module sram_like_arbiter #(
   parameter int OUTST    = 4,
   parameter int DATA_MAX = 3
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int PW = $clog2(OUTST);
   localparam int SW = $clog2(DATA_MAX + 1);
   localparam logic [PW:0]   FULL    = (PW+1)'(OUTST);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [SW-1:0] SMAX    = SW'(DATA_MAX);
   localparam logic [SW-1:0] S_ONE   = SW'(1);

   typedef enum logic {FREE = 1'b0, HOLD = 1'b1} state_e;

   state_e        state_q, state_d;
   logic          lock_owner_q, lock_owner_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [OUTST-1:0] fifo_q, fifo_d;
   logic [SW-1:0] streak_q, streak_d;

   logic winner, owner, sel_req, push, pop, head;

   // Arbitration: data normally wins a tie, inst wins once the data streak saturates.
   always_comb begin
      winner = data_req;
      if (inst_req && data_req) winner = (streak_q != SMAX);
   end

   // FSM: state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= FREE;
         lock_owner_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         lock_owner_q <= lock_owner_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d      = state_q;
      lock_owner_d = lock_owner_q;
      case (state_q)
         FREE: if (mem_req && !mem_addr_ok) begin
            state_d      = HOLD;
            lock_owner_d = owner;
         end
         HOLD: if (mem_addr_ok) state_d = FREE;
         default: state_d = FREE;
      endcase
   end

   // FSM: outputs (owner select and memory-side mux)
   always_comb begin
      owner = 1'b0;
      if (resetn) owner = (state_q == HOLD) ? lock_owner_q : winner;
      sel_req   = owner ? data_req   : inst_req;
      mem_req   = resetn & sel_req & (cnt_q != FULL);
      mem_wr    = owner ? data_wr    : inst_wr;
      mem_size  = owner ? data_size  : inst_size;
      mem_addr  = owner ? data_addr  : inst_addr;
      mem_wdata = owner ? data_wdata : inst_wdata;
   end

   assign push         = mem_req & mem_addr_ok;
   assign inst_addr_ok = push & ~owner;
   assign data_addr_ok = push & owner;

   assign head         = fifo_q[rptr_q];
   assign pop          = resetn & mem_data_ok & (cnt_q != '0);
   assign inst_data_ok = pop & ~head;
   assign data_data_ok = pop & head;
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   always_comb begin
      fifo_d = fifo_q;
      if (push) fifo_d[wptr_q] = owner;
      wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
      rptr_d = pop  ? rptr_q + PTR_ONE : rptr_q;
      cnt_d  = cnt_q;
      if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
   end

   // Streak counts data wins only while inst is actually waiting.
   always_comb begin
      streak_d = streak_q;
      if (!inst_req || inst_addr_ok)              streak_d = '0;
      else if (data_addr_ok && streak_q != SMAX)  streak_d = streak_q + S_ONE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fifo_q   <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         streak_q <= '0;
      end else begin
         fifo_q   <= fifo_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         streak_q <= streak_d;
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter with an owner/rdata scoreboard queue.
module tb_sram_like_arbiter;

   logic        clk, resetn;
   logic        inst_req, inst_wr, data_req, data_wr;
   logic [1:0]  inst_size, data_size, mem_size;
   logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
   logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
   logic [31:0] inst_rdata, data_rdata;
   logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic        owner;
      logic [31:0] rdata;
   } rsp_t;

   rsp_t sb[$];
   rsp_t cur;
   logic exp_pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

   sram_like_arbiter #(.OUTST(4), .DATA_MAX(3)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      inst_req    = 1'b0;
      data_req    = 1'b0;
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
   endtask

   // Expect an acceptance by master own this cycle and queue its future response.
   task automatic chk_acc(input string tag, input logic own, input logic [31:0] rd);
      rsp_t r;
      check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd1);
      check({tag, "_inst_aok"}, {31'd0, inst_addr_ok}, {31'd0, ~own});
      check({tag, "_data_aok"}, {31'd0, data_addr_ok}, {31'd0, own});
      r.owner = own;
      r.rdata = rd;
      sb.push_back(r);
   endtask

   task automatic prep_resp();
      check("sb_nonempty", {31'd0, (sb.size() != 0)}, 32'd1);
      if (sb.size() != 0) cur = sb.pop_front();
      else cur = '0;
      mem_data_ok = 1'b1;
      mem_rdata   = cur.rdata;
   endtask

   task automatic chk_resp(input string tag);
      check({tag, "_inst_dok"}, {31'd0, inst_data_ok}, {31'd0, ~cur.owner});
      check({tag, "_data_dok"}, {31'd0, data_data_ok}, {31'd0, cur.owner});
      check({tag, "_inst_rdata"}, inst_rdata, cur.rdata);
      check({tag, "_data_rdata"}, data_rdata, cur.rdata);
   endtask

   task automatic drain(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         prep_resp();
         #3;
         chk_resp(tag);
         tick();
         mem_data_ok = 1'b0;
      end
   endtask

   initial begin
      // reset values with both request and response inputs active
      resetn = 1'b0;
      inst_req = 1'b0; inst_wr = 1'b1; inst_size = 2'd1;
      inst_addr = 32'h1111; inst_wdata = 32'hAAAA;
      data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2;
      data_addr = 32'h2222; data_wdata = 32'hBBBB;
      mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0;
      #3;
      check("rst_mem_req", {31'd0, mem_req}, 32'd0);
      check("rst_mem_addr", mem_addr, 32'h1111);
      check("rst_mem_wr", {31'd0, mem_wr}, 32'd1);
      check("rst_mem_size", {30'd0, mem_size}, 32'd1);
      check("rst_data_aok", {31'd0, data_addr_ok}, 32'd0);
      check("rst_inst_dok", {31'd0, inst_data_ok}, 32'd0);
      check("rst_data_dok", {31'd0, data_data_ok}, 32'd0);
      check("rst_cnt", 32'(dut.cnt_q), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      idle();
      tick();

      // inst-only read
      inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1000;
      mem_addr_ok = 1'b1;
      #3;
      check("t1_mem_addr", mem_addr, 32'h1000);
      chk_acc("t1_acc", 1'b0, 32'hDEADBEEF);
      tick();
      idle();
      #3;
      check("t1_c1_inst_dok", {31'd0, inst_data_ok}, 32'd0);
      check("t1_c1_data_dok", {31'd0, data_data_ok}, 32'd0);
      tick();
      drain("t1_rsp", 1);

      // both requesting, memory stalls: data locked for 4 cycles
      inst_req = 1'b1; inst_addr = 32'h3000;
      data_req = 1'b1; data_addr = 32'h4000; data_wr = 1'b1; data_wdata = 32'h55AA;
      mem_addr_ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #3;
         check("t2_hold_addr", mem_addr, 32'h4000);
         check("t2_hold_wdata", mem_wdata, 32'h55AA);
         check("t2_hold_data_aok", {31'd0, data_addr_ok}, 32'd0);
         check("t2_hold_inst_aok", {31'd0, inst_addr_ok}, 32'd0);
         tick();
      end
      mem_addr_ok = 1'b1;
      #3;
      check("t2_c3_addr", mem_addr, 32'h4000);
      chk_acc("t2_c3", 1'b1, 32'h0D0D0001);
      tick();
      data_req = 1'b0;
      #3;
      check("t2_inst_addr", mem_addr, 32'h3000);
      chk_acc("t2_inst", 1'b0, 32'h1A1A0002);
      tick();
      // lock data, then drop data_req during HOLD
      data_req = 1'b1; data_addr = 32'h5000; mem_addr_ok = 1'b0;
      #3;
      check("t2_d2_addr", mem_addr, 32'h5000);
      tick();
      data_req = 1'b0;
      #3;
      check("t2_drop_mem_req", {31'd0, mem_req}, 32'd0);
      check("t2_drop_addr", mem_addr, 32'h5000);
      check("t2_drop_inst_aok", {31'd0, inst_addr_ok}, 32'd0);
      tick();
      data_req = 1'b1; mem_addr_ok = 1'b1;
      #3;
      check("t2_d2_acc_addr", mem_addr, 32'h5000);
      chk_acc("t2_d2_acc", 1'b1, 32'h0D0D0003);
      tick();
      // lock inst, then data arrives during HOLD and must not steal the port
      data_req = 1'b0; mem_addr_ok = 1'b0;
      #3;
      check("t2_i_lock_addr", mem_addr, 32'h3000);
      tick();
      data_req = 1'b1;
      #3;
      check("t2_i_hold_addr", mem_addr, 32'h3000);
      tick();
      mem_addr_ok = 1'b1;
      #3;
      chk_acc("t2_i_acc", 1'b0, 32'h1A1A0004);
      tick();
      idle();
      drain("t2_rsp", 4);
      #3;
      check("t2_cnt", 32'(dut.cnt_q), 32'd0);

      // outstanding limit with a silent memory
      inst_req = 1'b1; inst_addr = 32'h6000; mem_addr_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #3;
         chk_acc("t3_fill", 1'b0, 32'h60000000 + i);
         tick();
      end
      prep_resp();
      #3;
      check("t3_full_mem_req", {31'd0, mem_req}, 32'd0);
      check("t3_full_inst_aok", {31'd0, inst_addr_ok}, 32'd0);
      chk_resp("t3_full_rsp");
      tick();
      mem_data_ok = 1'b0;
      #3;
      chk_acc("t3_fifth", 1'b0, 32'h60000004);
      tick();
      idle();
      drain("t3_rsp", 4);

      // interleaved I, D, I, D
      for (int i = 0; i < 4; i++) begin
         inst_req = (i % 2 == 0);
         data_req = (i % 2 == 1);
         mem_addr_ok = 1'b1;
         #3;
         chk_acc("t4_acc", (i % 2 == 1), 32'h40000000 + i);
         tick();
      end
      idle();
      drain("t4_rsp", 4);
      #3;
      check("t4_cnt", 32'(dut.cnt_q), 32'd0);

      // continuous contention: D, D, D, I repeating
      inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (sb.size() != 0) prep_resp();
         else mem_data_ok = 1'b0;
         #3;
         if (mem_data_ok) chk_resp("t5_rsp");
         chk_acc("t5_grant", exp_pat[i], 32'h50000000 + i);
         tick();
      end
      idle();
      drain("t5_tail", 1);

      // stray response with nothing outstanding
      mem_data_ok = 1'b1; mem_rdata = 32'hBAD0BAD0;
      #3;
      check("t6_stray_inst_dok", {31'd0, inst_data_ok}, 32'd0);
      check("t6_stray_data_dok", {31'd0, data_data_ok}, 32'd0);
      tick();
      mem_data_ok = 1'b0;
      #3;
      check("t6_stray_cnt", 32'(dut.cnt_q), 32'd0);

      // reset in the middle of three outstanding requests
      inst_req = 1'b1; inst_addr = 32'h7000; mem_addr_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
      end
      idle();
      #3;
      check("t6_cnt3", 32'(dut.cnt_q), 32'd3);
      inst_req = 1'b1;
      resetn = 1'b0;
      #1;
      check("t6_rst_cnt", 32'(dut.cnt_q), 32'd0);
      check("t6_rst_mem_req", {31'd0, mem_req}, 32'd0);
      tick();
      resetn = 1'b1;
      idle();
      #3;
      check("t6_post_cnt", 32'(dut.cnt_q), 32'd0);
      check("t6_post_state", 32'(dut.state_q), 32'd0);
      sb.delete();
      tick();
      data_req = 1'b1; data_addr = 32'h8000; mem_addr_ok = 1'b1;
      #3;
      chk_acc("t6_after", 1'b1, 32'h12345678);
      tick();
      idle();
      tick();
      drain("t6_after_rsp", 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
